updown_counter_gen: RTL and testbench
=====================================

Name: updown_counter_gen

Overview:
Parametrised next-generation free-running counter with a selectable true/complement narrow output tap.
- Generalised width, output tap width, step size and direction.
- Adds synchronous load, count enable, wrap or saturate end behaviour, a terminal-count pulse and a sticky overflow flag.
- Used as a general event/timebase counter in datapath control logic.

Parameters:
WIDTH, 16, counter register width (>= 2)
OUT_WIDTH, 4, width of count_out tap (1..WIDTH), taken from LSBs
STEP, 1, increment/decrement amount (1..2^WIDTH-1)
SATURATE, 0, 0 = wrap at bounds, 1 = clamp at bounds

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
enable  input  1  count enable
dir  input  1  1 = count up, 0 = count down
load  input  1  synchronous load strobe
load_val  input  WIDTH  value loaded when load=1
select  input  1  1 = count_out carries bitwise complement of tap
clr_ovf  input  1  clears sticky ovf flag
count  output  WIDTH  current counter register
count_out  output  OUT_WIDTH  registered (optionally complemented) low tap
tc  output  1  one-cycle terminal-count pulse
ovf  output  1  sticky overflow/underflow flag

Behaviour:
- One clock, clk; reset synchronous, active-high, highest priority.
- Reset values: count=0, count_out=0, tc=0, ovf=0.
- Priority per cycle: reset > load > enable > hold.
- load=1: count <= load_val; tc <= 0; ovf unaffected except via clr_ovf. enable is ignored that cycle.
- enable=1, dir=1: next = count + STEP, computed at WIDTH+1 bits.
  - If the carry bit is set: SATURATE=0 gives the wrapped WIDTH-bit result; SATURATE=1 gives all-ones. This is a bound event.
- enable=1, dir=0: next = count - STEP.
  - If a borrow occurs: SATURATE=0 gives the wrapped result; SATURATE=1 gives 0. This is a bound event.
- SATURATE=1 at bound with further counting toward the bound:
  - count holds.
  - Each such cycle is still a bound event, so tc pulses every cycle while pinned.
- enable=0: count holds; tc <= 0.
- tc: registered, equals 1 in the cycle after a bound event, else 0.
- ovf: set on any bound event.
  - clr_ovf clears it.
  - Simultaneous bound event and clr_ovf: set wins.
  - Unaffected by load.
- count_out: registered, one cycle behind count.
  - count_out <= select ? ~count[OUT_WIDTH-1:0] : count[OUT_WIDTH-1:0], sampled from the pre-update count value.
  - Updates every non-reset cycle regardless of enable/load.
  - select is sampled each cycle; no effect on count.
- Reset asserted mid-count: all outputs return to reset values on that edge. The first count after deassertion starts from 0.
- No combinational path from inputs to outputs.

Optional Feature:
COUNTER_MATCH_EN
- Defined:
  - Adds input match_val [WIDTH] and output match [1].
  - match is registered: 1 in the cycle after count == match_val (pre-update value), else 0.
  - Reset value 0.
  - Comparison is independent of enable/load.
- Undefined: the match_val and match ports do not exist; no comparator logic.

Test Plan:
- Defaults, reset 2 cycles, then enable=1, dir=1, select=0 for 20 cycles -> count 1..20. count_out trails count by one cycle: 0,1,..,15,0,1,2,3. tc=0, ovf=0.
- select=1 with count=5 -> next cycle count_out=4'hA. Deassert enable -> count holds 5, count_out stays 4'hA.
- SATURATE=0: load 16'hFFFE, enable up -> count FFFF, 0000. tc=1 exactly one cycle after the wrap edge. ovf=1 until clr_ovf=1, then 0. Assert clr_ovf on a wrap edge -> ovf stays 1.
- SATURATE=1, STEP=3: load 16'h0002, dir=0 -> count 0000 and holds. tc=1 on every cycle while enabled and pinned. ovf=1.
- load=1 with enable=1, load_val=16'h1234 -> count=1234 next cycle, no step applied. Then reset asserted mid-count -> count=0, count_out=0, tc=0, ovf=0 on that edge.
- COUNTER_MATCH_EN defined, match_val=16'h0007, counting up from 0 -> match=1 for exactly one cycle, the cycle where count=8.

Source files
------------

// File: rtl/updown_counter_gen.sv
// Up/down counter with step, wrap/saturate bounds, tc pulse, sticky ovf and a registered low tap.
// All outputs are registered (one cycle); no backpressure. Optional COUNTER_MATCH_EN adds match_val/match.
module updown_counter_gen #(
   parameter int WIDTH     = 16,
   parameter int OUT_WIDTH = 4,
   parameter int STEP      = 1,
   parameter int SATURATE  = 0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic                 dir,
   input  logic                 load,
   input  logic [WIDTH-1:0]     load_val,
   input  logic                 select,
   input  logic                 clr_ovf,
   output logic [WIDTH-1:0]     count,
   output logic [OUT_WIDTH-1:0] count_out,
   output logic                 tc,
   output logic                 ovf
`ifdef COUNTER_MATCH_EN
   ,
   input  logic [WIDTH-1:0]     match_val,
   output logic                 match
`endif
);

   localparam logic [WIDTH:0] STEP_W = (WIDTH+1)'(STEP);

   logic [WIDTH-1:0]     count_q, count_d;
   logic [OUT_WIDTH-1:0] count_out_q, count_out_d;
   logic                 tc_q, tc_d;
   logic                 ovf_q, ovf_d;
   logic [WIDTH:0]       sum, diff;
   logic                 bound;

   always_comb begin
      sum         = {1'b0, count_q} + STEP_W;
      diff        = {1'b0, count_q} - STEP_W;
      count_d     = count_q;
      bound       = 1'b0;
      count_out_d = select ? ~count_q[OUT_WIDTH-1:0] : count_q[OUT_WIDTH-1:0];
      if (load) begin
         count_d = load_val;
      end else if (enable) begin
         // Carry/borrow out of the extended result marks a bound event; clamping holds the pinned value.
         if (dir) begin
            bound   = sum[WIDTH];
            count_d = (bound && SATURATE != 0) ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
         end else begin
            bound   = diff[WIDTH];
            count_d = (bound && SATURATE != 0) ? {WIDTH{1'b0}} : diff[WIDTH-1:0];
         end
      end
      tc_d  = bound;
      ovf_d = bound | (ovf_q & ~clr_ovf);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q     <= '0;
         count_out_q <= '0;
         tc_q        <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         count_q     <= count_d;
         count_out_q <= count_out_d;
         tc_q        <= tc_d;
         ovf_q       <= ovf_d;
      end
   end

   assign count     = count_q;
   assign count_out = count_out_q;
   assign tc        = tc_q;
   assign ovf       = ovf_q;

`ifdef COUNTER_MATCH_EN
   logic match_q, match_d;

   always_comb begin
      match_d = (count_q == match_val);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         match_q <= 1'b0;
      end else begin
         match_q <= match_d;
      end
   end

   assign match = match_q;
`endif

endmodule

// File: tb/tb_updown_counter_gen.sv
// Bench for updown_counter_gen: a wrapping STEP=1 instance and a saturating STEP=3 instance share stimulus.
module tb_updown_counter_gen;

   localparam longint MAXV = 65535;

   logic        clk = 1'b0;
   logic        reset, enable, dir, load, select, clr_ovf;
   logic [15:0] load_val, match_val;
   logic [15:0] count0, count1;
   logic [3:0]  cout0, cout1;
   logic        tc0, tc1, ovf0, ovf1;
`ifdef COUNTER_MATCH_EN
   logic        match0, match1;
`endif

   int n_pass  = 0;
   int n_total = 0;

   longint m_cnt [2];
   longint m_out [2];
   bit     m_tc  [2];
   bit     m_ovf [2];
   bit     m_match;
   int     m_step [2] = '{1, 3};
   bit     m_sat  [2] = '{0, 1};

   always #5 clk = ~clk;

   updown_counter_gen #(.WIDTH(16), .OUT_WIDTH(4), .STEP(1), .SATURATE(0)) dut_wrap (
      .clk(clk), .reset(reset), .enable(enable), .dir(dir), .load(load),
      .load_val(load_val), .select(select), .clr_ovf(clr_ovf),
      .count(count0), .count_out(cout0), .tc(tc0), .ovf(ovf0)
`ifdef COUNTER_MATCH_EN
      , .match_val(match_val), .match(match0)
`endif
   );

   updown_counter_gen #(.WIDTH(16), .OUT_WIDTH(4), .STEP(3), .SATURATE(1)) dut_sat (
      .clk(clk), .reset(reset), .enable(enable), .dir(dir), .load(load),
      .load_val(load_val), .select(select), .clr_ovf(clr_ovf),
      .count(count1), .count_out(cout1), .tc(tc1), .ovf(ovf1)
`ifdef COUNTER_MATCH_EN
      , .match_val(match_val), .match(match1)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Advance the reference model from the current inputs, clock once, then compare.
   task automatic step(input string tag);
      m_match = !reset && (m_cnt[0] == longint'(match_val));
      for (int i = 0; i < 2; i++) begin
         if (reset) begin
            m_cnt[i] = 0; m_out[i] = 0; m_tc[i] = 0; m_ovf[i] = 0;
         end else begin
            bit     b = 0;
            longint n = m_cnt[i];
            m_out[i] = (select ? ~m_cnt[i] : m_cnt[i]) & 15;
            if (load) begin
               n = longint'(load_val);
            end else if (enable) begin
               if (dir) begin
                  n = m_cnt[i] + m_step[i];
                  if (n > MAXV) begin b = 1; n = m_sat[i] ? MAXV : n - (MAXV + 1); end
               end else begin
                  n = m_cnt[i] - m_step[i];
                  if (n < 0) begin b = 1; n = m_sat[i] ? 0 : n + (MAXV + 1); end
               end
            end
            m_tc[i]  = b;
            m_ovf[i] = b || (m_ovf[i] && !clr_ovf);
            m_cnt[i] = n;
         end
      end
      @(posedge clk);
      #1;
      check({tag, ".w.count"}, 32'(count0), 32'(m_cnt[0]));
      check({tag, ".w.cout"},  32'(cout0),  32'(m_out[0]));
      check({tag, ".w.tc"},    32'(tc0),    32'(m_tc[0]));
      check({tag, ".w.ovf"},   32'(ovf0),   32'(m_ovf[0]));
      check({tag, ".s.count"}, 32'(count1), 32'(m_cnt[1]));
      check({tag, ".s.cout"},  32'(cout1),  32'(m_out[1]));
      check({tag, ".s.tc"},    32'(tc1),    32'(m_tc[1]));
      check({tag, ".s.ovf"},   32'(ovf1),   32'(m_ovf[1]));
`ifdef COUNTER_MATCH_EN
      check({tag, ".match"},   32'(match0), 32'(m_match));
`endif
   endtask

   task automatic drive(input logic r, input logic en, input logic d, input logic ld,
                        input logic [15:0] lv, input logic sel, input logic clr);
      reset = r; enable = en; dir = d; load = ld; load_val = lv; select = sel; clr_ovf = clr;
   endtask

   initial begin
      match_val = 16'h0007;
      for (int i = 0; i < 2; i++) begin
         m_cnt[i] = 0; m_out[i] = 0; m_tc[i] = 0; m_ovf[i] = 0;
      end
      drive(1, 0, 0, 0, 16'h0, 0, 0);
      #1;
      step("reset");
      step("reset");

      // Count up 20 cycles; tap trails the count by one cycle.
      drive(0, 1, 1, 0, 16'h0, 0, 0);
      for (int i = 0; i < 20; i++) step("up20");

      // Complemented tap and hold.
      drive(0, 0, 1, 1, 16'h0005, 0, 0);
      step("load5");
      drive(0, 0, 1, 0, 16'h0, 1, 0);
      step("sel");
      step("hold");
      step("hold");

      // Wrap at top, clear ovf, then clr_ovf coinciding with a wrap.
      drive(0, 0, 1, 1, 16'hFFFE, 0, 0);
      step("loadfffe");
      drive(0, 1, 1, 0, 16'h0, 0, 0);
      for (int i = 0; i < 3; i++) step("wrapup");
      drive(0, 0, 1, 0, 16'h0, 0, 1);
      step("clrovf");
      drive(0, 0, 1, 1, 16'hFFFF, 0, 0);
      step("loadffff");
      drive(0, 1, 1, 0, 16'h0, 0, 1);
      step("wrapclr");
      drive(0, 0, 1, 0, 16'h0, 0, 0);
      step("afterclr");

      // Count down through zero: wrap on one instance, pinned at 0 on the other.
      drive(0, 0, 0, 1, 16'h0002, 0, 0);
      step("load2");
      drive(0, 1, 0, 0, 16'h0, 0, 0);
      for (int i = 0; i < 5; i++) step("down");

      // Load overrides enable, then reset mid-count.
      drive(0, 1, 1, 1, 16'h1234, 0, 0);
      step("loaden");
      drive(0, 1, 1, 0, 16'h0, 1, 0);
      step("post1234");
      step("post1234");
      drive(1, 1, 1, 0, 16'h0, 1, 0);
      step("midreset");

      // Count up from zero past match_val.
      drive(0, 1, 1, 0, 16'h0, 0, 0);
      for (int i = 0; i < 11; i++) step("match");

      // Randomized traffic, biased toward the bounds via occasional loads.
      for (int i = 0; i < 400; i++) begin
         logic [15:0] lv;
         case ($urandom_range(0, 3))
            0: lv = 16'($urandom_range(0, 5));
            1: lv = 16'(65535 - $urandom_range(0, 5));
            default: lv = 16'($urandom);
         endcase
         match_val = ($urandom_range(0, 3) == 0) ? count0 : 16'($urandom);
         drive($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, 1'($urandom),
               $urandom_range(0, 9) == 0, lv, 1'($urandom), $urandom_range(0, 7) == 0);
         step("rand");
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
